// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: one DATA_W payload, valid/ready on both sides, synchronous flush.
// Optional second (skid) entry enabled by defining PIPE_SKID_EN; default build is single-entry.
module pipe_stage_reg #(
   parameter int DATA_W     = 197,
   parameter bit CLEAR_DATA = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   // Handshake: a beat moves on a side exactly when valid & ready are both high at a rising
   // edge; valid never waits on ready, and a held beat's data is stable until it moves.

   // State encoding equals the entry count, so occupancy doubles as the visible FSM state.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              accept;
   logic              drain;
   logic              load_main_in;
   logic [DATA_W-1:0] main_q;
`ifdef PIPE_SKID_EN
   logic              load_skid;
   logic              skid_to_main;
   logic [DATA_W-1:0] skid_q;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= EMPTY;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: if (accept) state_nxt = BUSY;
            BUSY: begin
               if (drain && !accept) state_nxt = EMPTY;
`ifdef PIPE_SKID_EN
               else if (accept && !drain) state_nxt = FULL;
`endif
            end
            FULL:    if (drain) state_nxt = BUSY;
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_comb begin
      out_valid = (state != EMPTY);
`ifdef PIPE_SKID_EN
      // Depends on registered state only: no out_ready -> in_ready path.
      in_ready  = (state != FULL);
`else
      in_ready  = !out_valid || out_ready;
`endif
      occupancy    = state;
      accept       = in_valid && in_ready;
      drain        = out_valid && out_ready;
      load_main_in = !flush && accept && ((state == EMPTY) || drain);
`ifdef PIPE_SKID_EN
      load_skid    = !flush && accept && (state == BUSY) && !drain;
      skid_to_main = !flush && (state == FULL) && drain;
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         main_q <= '0;
      end else if (flush) begin
         if (CLEAR_DATA) main_q <= '0;
      end else if (load_main_in) begin
         main_q <= in_data;
`ifdef PIPE_SKID_EN
      end else if (skid_to_main) begin
         main_q <= skid_q;
`endif
      end
   end

`ifdef PIPE_SKID_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         skid_q <= '0;
      end else if (flush) begin
         if (CLEAR_DATA) skid_q <= '0;
      end else if (load_skid) begin
         skid_q <= in_data;
      end
   end
`endif

   assign out_data = main_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a 197-bit CLEAR_DATA=1 instance and an 8-bit CLEAR_DATA=0 instance
// share one stimulus stream and are checked against a queue-based reference model.
module tb_pipe_stage_reg;

   localparam int DW = 197;
   localparam int NW = 8;
`ifdef PIPE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          out_ready;
   logic [DW-1:0] in_data;

   logic          in_ready_w, out_valid_w;
   logic [DW-1:0] out_data_w;
   logic [1:0]    occ_w;
   logic          in_ready_n, out_valid_n;
   logic [NW-1:0] out_data_n;
   logic [1:0]    occ_n;

   // Reference model: FIFO contents plus the value the output register shows when empty.
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] held_w;
   logic [NW-1:0] held_n;

   int n_checks = 0;
   int n_pass   = 0;

   pipe_stage_reg #(.DATA_W(DW), .CLEAR_DATA(1'b1)) u_wide (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
      .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
      .occupancy(occ_w)
   );

   pipe_stage_reg #(.DATA_W(NW), .CLEAR_DATA(1'b0)) u_narrow (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data[NW-1:0]),
      .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n),
      .occupancy(occ_n)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic model_ready(input logic ordy);
      if (CAP == 2) return exp_q.size() < 2;
      return (exp_q.size() == 0) || ordy;
   endfunction

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl,
                       output logic took);
      logic          rdy;
      logic [DW-1:0] disp_w;
      logic [NW-1:0] disp_n;
      logic [DW-1:0] popped;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      #1;
      rdy    = model_ready(ordy);
      disp_w = (exp_q.size() != 0) ? exp_q[0] : held_w;
      disp_n = (exp_q.size() != 0) ? exp_q[0][NW-1:0] : held_n;
      check("in_ready_w",  in_ready_w,  rdy);
      check("in_ready_n",  in_ready_n,  rdy);
      check("out_valid_w", out_valid_w, exp_q.size() != 0);
      check("out_valid_n", out_valid_n, exp_q.size() != 0);
      check("occ_w",       occ_w,       exp_q.size());
      check("occ_n",       occ_n,       exp_q.size());
      check("out_data_w",  out_data_w,  disp_w);
      check("out_data_n",  out_data_n,  disp_n);
      took = iv && rdy;
      @(posedge clock);
      if (exp_q.size() != 0 && ordy) begin
         popped = exp_q.pop_front();
         if (exp_q.size() == 0) begin
            held_w = popped;
            held_n = popped[NW-1:0];
         end
      end
      if (fl) begin
         exp_q.delete();
         held_w = '0;
         held_n = disp_n;
      end else if (took) begin
         exp_q.push_back(d);
      end
      @(negedge clock);
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      #1;
      check("rst_out_valid_w", out_valid_w, 1'b0);
      check("rst_out_valid_n", out_valid_n, 1'b0);
      check("rst_occ_w",       occ_w,       2'd0);
      check("rst_occ_n",       occ_n,       2'd0);
      check("rst_out_data_w",  out_data_w,  '0);
      check("rst_out_data_n",  out_data_n,  '0);
      exp_q.delete();
      held_w = '0;
      held_n = '0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] r = '0;
      for (int k = 0; k < 7; k++) r = {r[DW-33:0], $urandom()};
      return r;
   endfunction

   initial begin
      logic          took;
      logic [DW-1:0] bp_list[3];
      int            idx;
      int            peak;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      held_w = '0; held_n = '0;
      @(negedge clock);
      reset_pulse();

      // Streaming 1..16 at full rate.
      for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b1, 1'b0, took);
      step(1'b0, '0, 1'b1, 1'b0, took);
      step(1'b0, '0, 1'b1, 1'b0, took);

      // Reset with one beat held.
      step(1'b1, DW'('h77), 1'b0, 1'b0, took);
      check("occ_before_reset", occ_w, 2'd1);
      reset_pulse();
      step(1'b0, '0, 1'b1, 1'b0, took);

      // Back-pressure: A,B,C with out_ready low for three cycles, C held upstream.
      bp_list[0] = DW'('hA); bp_list[1] = DW'('hB); bp_list[2] = DW'('hC);
      idx = 0;
      peak = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         step(idx < 3, (idx < 3) ? bp_list[idx] : '0, cyc >= 3, 1'b0, took);
         if (took) idx++;
         if (int'(occ_w) > peak) peak = int'(occ_w);
         if (cyc >= 3 && idx == 3 && exp_q.size() == 0) break;
      end
      check("bp_all_sent", DW'(idx), DW'(3));
      check("bp_peak_occ", DW'(peak), DW'(CAP));
      check("bp_drained_valid", out_valid_w, 1'b0);

      // Flush with the stage as full as it gets and 0x55 offered.
      step(1'b1, DW'('h11), 1'b0, 1'b0, took);
      step(1'b1, DW'('h22), 1'b0, 1'b0, took);
      step(1'b1, DW'('h55), 1'b0, 1'b1, took);
      step(1'b0, '0, 1'b1, 1'b0, took);
      check("flush_data_w", out_data_w, '0);
      // Flush with one beat held while downstream takes it.
      step(1'b1, DW'('h33), 1'b0, 1'b0, took);
      step(1'b1, DW'('h55), 1'b1, 1'b1, took);
      step(1'b0, '0, 1'b1, 1'b0, took);
      check("flush2_data_n", out_data_n, NW'('h33));

      // Random traffic with 5% flushes.
      for (int i = 0; i < 10000; i++) begin
         step($urandom_range(0, 3) != 0, rand_data(), $urandom_range(0, 3) != 0,
              $urandom_range(0, 99) < 5, took);
         if (occ_w > 2'd2) check("occ_bound", occ_w, 2'd2);
      end
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, took);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
